// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word, RAM handshake state and the arbiter FSM encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arbstate_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the arbiter's requester and RAM-side signals, one modport per side.
interface ram_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   word_t     iload;
   logic      iwait;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   word_t     dload;
   logic      dwait;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;
   logic      ram_err;

   modport arb (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
   );

   modport tb (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
   );

endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory. D has priority,
// I is forced after DMAX consecutive D grants; a grant is abandoned after TIMEOUT cycles.
module ram_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned DMAX    = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic      CLK,
   input  logic      RST,
   input  logic      iREN,
   input  word_t     iaddr,
   output word_t     iload,
   output logic      iwait,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output word_t     dload,
   output logic      dwait,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate,
   output logic      ram_err,
   output arbstate_t state_o,
   output logic [3:0] dcnt_o
);

   localparam logic [3:0] DMAX_C    = 4'(DMAX);
   localparam logic [7:0] TLIMIT_C  = 8'(TIMEOUT - 1);

   arbstate_t  state_q, state_d;
   logic [3:0] dcnt_q, dcnt_d;
   logic [7:0] tcnt_q, tcnt_d;

   logic  d_req;
   logic  ram_done;
   logic  timed_out;
   logic  finish;
   logic  xfer_err;
   word_t xfer_load;

   assign state_o = state_q;
   assign dcnt_o  = dcnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         dcnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // A timeout completion returns zero data; a RAM completion returns ramload.
   always_comb begin
      d_req     = dREN | dWEN;
      ram_done  = (ramstate == ACCESS) || (ramstate == ERROR);
      timed_out = (tcnt_q == TLIMIT_C);
      finish    = ram_done || timed_out;
      xfer_load = ram_done ? ramload : '0;
      xfer_err  = (ramstate == ERROR) || !ram_done;

      state_d  = state_q;
      dcnt_d   = dcnt_q;
      tcnt_d   = tcnt_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = iREN;
      dwait    = d_req;
      iload    = '0;
      dload    = '0;
      ram_err  = 1'b0;

      unique case (state_q)
         IDLE: begin
            tcnt_d = '0;
            if (d_req && !(iREN && dcnt_q == DMAX_C)) begin
               state_d = DGNT;
               if (iREN) dcnt_d = (dcnt_q == 4'hF) ? dcnt_q : dcnt_q + 4'd1;
               else      dcnt_d = '0;
            end else if (iREN) begin
               state_d = IGNT;
               dcnt_d  = '0;
            end
         end
         IGNT: begin
            if (!iREN) begin
               state_d = IDLE;
               tcnt_d  = '0;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (finish) begin
                  iwait   = 1'b0;
                  iload   = xfer_load;
                  ram_err = xfer_err;
                  state_d = IDLE;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         DGNT: begin
            if (!d_req) begin
               state_d = IDLE;
               tcnt_d  = '0;
            end else begin
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               ramaddr  = daddr;
               ramstore = dstore;
               if (finish) begin
                  dwait   = 1'b0;
                  dload   = xfer_load;
                  ram_err = xfer_err;
                  state_d = IDLE;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            dcnt_d  = '0;
            tcnt_d  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: each completion is predicted into exp_q and a
// negedge monitor pops and compares {port, err, wen, addr, load} when one occurs.
module tb_ram_arbiter;
   import cpu_types_pkg::*;

   logic       clk;
   logic       rst;
   logic       iREN;
   word_t      iaddr;
   word_t      iload;
   logic       iwait;
   logic       dREN;
   logic       dWEN;
   word_t      daddr;
   word_t      dstore;
   word_t      dload;
   logic       dwait;
   logic       ramREN;
   logic       ramWEN;
   word_t      ramaddr;
   word_t      ramstore;
   word_t      ramload;
   ramstate_t  ramstate;
   logic       ram_err;
   arbstate_t  state_o;
   logic [3:0] dcnt_o;

   int checks;
   int errors;

   // {port(1=D), ram_err, ramWEN, ramaddr, load}
   logic [66:0] exp_q[$];
   logic [66:0] mon_act;
   logic [66:0] mon_exp;
   logic        i_done;
   logic        d_done;

   ram_arbiter #(.DMAX(4), .TIMEOUT(8)) dut (
      .CLK(clk), .RST(rst),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err),
      .state_o(state_o), .dcnt_o(dcnt_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic port, input logic err, input logic wen,
                       input word_t addr, input word_t load);
      exp_q.push_back({port, err, wen, addr, load});
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst) begin
         i_done = iREN && !iwait;
         d_done = (dREN || dWEN) && !dwait;
         if (i_done || d_done) begin
            mon_act = {d_done, ram_err, ramWEN, ramaddr, d_done ? dload : iload};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_completion act=%h exp=none", mon_act);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_act !== mon_exp) begin
                  errors++;
                  $display("FAIL completion act=%h exp=%h", mon_act, mon_exp);
               end
            end
         end else if (ram_err) begin
            checks++;
            errors++;
            $display("FAIL stray_ram_err act=1 exp=0 state=%0d", state_o);
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      iREN     = 1'b1;
      iaddr    = 32'h0000_0040;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = FREE;

      // 1. reset with iREN held, then a single-cycle I access
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_iwait", 32'(iwait), 32'd1);
      chk("rst_state", 32'(state_o), 32'(IDLE));
      chk("rst_ram_err", 32'(ram_err), 32'd0);
      tick();
      rst      = 1'b0;
      ramstate = ACCESS;
      ramload  = 32'h1111_0000;
      push(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h1111_0000);
      @(negedge clk);
      chk("t1_idle_ramREN", 32'(ramREN), 32'd0);
      tick();
      @(negedge clk);
      chk("t1_grant_ramREN", 32'(ramREN), 32'd1);
      tick();
      iREN     = 1'b0;
      ramstate = FREE;

      // 2. contention: four D writes win, then I is forced
      tick();
      iREN     = 1'b1;
      iaddr    = 32'h0000_0080;
      dWEN     = 1'b1;
      daddr    = 32'h0000_0100;
      dstore   = 32'hDEAD_BEEF;
      ramstate = ACCESS;
      ramload  = 32'hA5A5_0000;
      repeat (4) push(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_0000);
      push(1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'hA5A5_0000);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin
            @(negedge clk);
            chk("t2_ramstore", ramstore, 32'hDEAD_BEEF);
         end
         if (c == 2) begin
            @(negedge clk);
            chk("t2_gap_ramWEN", 32'(ramWEN), 32'd0);
            chk("t2_gap_state", 32'(state_o), 32'(IDLE));
         end
         if (c == 8) begin
            @(negedge clk);
            chk("t2_dcnt_sat", 32'(dcnt_o), 32'd4);
         end
      end
      iREN     = 1'b0;
      dWEN     = 1'b0;
      ramstate = FREE;

      // 3. D read with three BUSY wait states
      tick();
      dREN     = 1'b1;
      daddr    = 32'h0000_0200;
      ramstate = BUSY;
      push(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h1234_5678);
      @(negedge clk);
      chk("t3_idle_dwait", 32'(dwait), 32'd1);
      for (int b = 0; b < 3; b++) begin
         tick();
         @(negedge clk);
         chk("t3_busy_dwait", 32'(dwait), 32'd1);
         chk("t3_busy_ramREN", 32'(ramREN), 32'd1);
      end
      tick();
      ramstate = ACCESS;
      ramload  = 32'h1234_5678;
      tick();
      dREN     = 1'b0;
      ramstate = FREE;

      // 4a. ERROR completion on an I grant
      tick();
      iREN     = 1'b1;
      iaddr    = 32'h0000_0300;
      ramstate = ERROR;
      ramload  = 32'h0BAD_0BAD;
      push(1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0BAD_0BAD);
      tick();
      tick();
      iREN     = 1'b0;
      ramstate = FREE;

      // 4b. timeout on the 8th grant cycle returns zero data
      tick();
      iREN     = 1'b1;
      iaddr    = 32'h0000_0304;
      ramstate = BUSY;
      ramload  = 32'hFFFF_FFFF;
      push(1'b0, 1'b1, 1'b0, 32'h0000_0304, 32'h0000_0000);
      for (int g = 1; g <= 8; g++) begin
         tick();
         if (g == 7) begin
            @(negedge clk);
            chk("t4_g7_iwait", 32'(iwait), 32'd1);
         end
      end
      tick();
      iREN     = 1'b0;
      ramstate = FREE;

      // 5. D abort on the second BUSY cycle
      tick();
      dREN     = 1'b1;
      daddr    = 32'h0000_0400;
      ramstate = BUSY;
      tick();
      @(negedge clk);
      chk("t5_busy1_ramREN", 32'(ramREN), 32'd1);
      tick();
      dREN = 1'b0;
      @(negedge clk);
      chk("t5_abort_ramREN", 32'(ramREN), 32'd0);
      chk("t5_abort_ram_err", 32'(ram_err), 32'd0);
      tick();
      @(negedge clk);
      chk("t5_after_state", 32'(state_o), 32'(IDLE));
      ramstate = FREE;

      // 6. reset during a D write BUSY cycle
      tick();
      iREN     = 1'b1;
      iaddr    = 32'h0000_0600;
      dWEN     = 1'b1;
      daddr    = 32'h0000_0500;
      dstore   = 32'hCAFE_F00D;
      ramstate = BUSY;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_pre_ramWEN", 32'(ramWEN), 32'd1);
      chk("t6_pre_dcnt", 32'(dcnt_o), 32'd1);
      tick();
      rst      = 1'b0;
      iREN     = 1'b0;
      dWEN     = 1'b0;
      ramstate = FREE;
      @(negedge clk);
      chk("t6_post_ramWEN", 32'(ramWEN), 32'd0);
      chk("t6_post_state", 32'(state_o), 32'(IDLE));
      chk("t6_post_dcnt", 32'(dcnt_o), 32'd0);

      repeat (3) tick();
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
